// File: rtl/des_pkg.sv
// DES constants and bit-exact permutation helpers shared by the decryption core.
// All tables use DES numbering: entry value 1 refers to the MSB of the source word.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Key-schedule shift amounts, entry k-1 holds the shift for schedule step k.
    localparam logic [1:0] SHIFT_T [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // S-boxes in row-major order; index = {b1, b6, b2..b5} of the 6-bit group.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
          0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
          15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
          3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
          13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
          13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
          1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
          13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
          3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
          14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
          11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
          10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
          4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
          13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
          6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
          1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
          2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    // Drops the eight parity bits while selecting the 56 key bits into C||D.
    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
        return y;
    endfunction

    // Shift for decryption round index r (0-based): walks the schedule backwards.
    function automatic logic [1:0] dec_shift(input logic [4:0] r);
        logic [3:0] idx;
        idx = 4'd15 - r[3:0];
        return SHIFT_T[idx];
    endfunction

    // Right rotation of a 28-bit key half by one or two positions.
    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] sh);
        return (sh == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_round_f.sv
// DES round function f(R, K) = P(S(E(R) ^ K)), purely combinational.
module des_round_f
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);

    logic [47:0] x;
    logic [31:0] s_out;

    assign x = e_exp(r) ^ k;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sbox
            logic [5:0] six;
            assign six = x[47-6*gi -: 6];
            // Outer bits select the row, inner four the column.
            assign s_out[31-4*gi -: 4] = SBOX[gi][{six[5], six[0], six[4:1]}];
        end
    endgenerate

    assign f = p_perm(s_out);

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core with valid/ready handshakes on both sides.
// ROUNDS_PER_CYCLE Feistel rounds are chained per clock (legal: 1,2,4,8,16).
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] dat_in,
    input  logic [63:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] dat_out
);

    localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic [31:0] l_reg, r_reg;
    logic [27:0] c_reg, d_reg;
    logic [63:0] dat_out_reg;
    logic        armed_reg;   // holds in_ready low while rst_n is asserted

    logic        accept;
    logic        last_step;

    // Round pipeline taps: index 0 is the register contents, index N after N rounds.
    logic [31:0] l_s [0:ROUNDS_PER_CYCLE];
    logic [31:0] r_s [0:ROUNDS_PER_CYCLE];
    logic [27:0] c_s [0:ROUNDS_PER_CYCLE];
    logic [27:0] d_s [0:ROUNDS_PER_CYCLE];

    assign accept    = in_valid && in_ready;
    assign last_step = (state_reg == ROUND) && ((cnt_reg + STEP) == 5'd16);

    assign l_s[0] = l_reg;
    assign r_s[0] = r_reg;
    assign c_s[0] = c_reg;
    assign d_s[0] = d_reg;

    genvar gi;
    generate
        for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_stage
            logic [47:0] subkey;
            logic [31:0] f_out;
            logic [1:0]  sh;

            // Subkey from the current halves; the first one uses unrotated C0/D0.
            assign subkey = pc2({c_s[gi], d_s[gi]});
            assign sh     = dec_shift(cnt_reg + 5'(gi));

            des_round_f u_f (
                .r (r_s[gi]),
                .k (subkey),
                .f (f_out)
            );

            assign l_s[gi+1] = r_s[gi];
            assign r_s[gi+1] = l_s[gi] ^ f_out;
            assign c_s[gi+1] = rotr28(c_s[gi], sh);
            assign d_s[gi+1] = rotr28(d_s[gi], sh);
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept, run rounds, hold result until the sink takes it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = ROUND;
            ROUND:   if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = armed_reg;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load on accept, advance rounds, capture plaintext on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_reg   <= 1'b0;
            cnt_reg     <= '0;
            l_reg       <= '0;
            r_reg       <= '0;
            c_reg       <= '0;
            d_reg       <= '0;
            dat_out_reg <= '0;
        end else begin
            armed_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        {l_reg, r_reg} <= ip(dat_in);
                        {c_reg, d_reg} <= pc1(key_in);
                        cnt_reg        <= '0;
                    end
                end
                ROUND: begin
                    l_reg   <= l_s[ROUNDS_PER_CYCLE];
                    r_reg   <= r_s[ROUNDS_PER_CYCLE];
                    c_reg   <= c_s[ROUNDS_PER_CYCLE];
                    d_reg   <= d_s[ROUNDS_PER_CYCLE];
                    cnt_reg <= last_step ? 5'd0 : (cnt_reg + STEP);
                    if (last_step) begin
                        // Halves are swapped before the final permutation.
                        dat_out_reg <= fp({r_s[ROUNDS_PER_CYCLE], l_s[ROUNDS_PER_CYCLE]});
                    end
                end
                default: ;
            endcase
        end
    end

    assign dat_out = dat_out_reg;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed-vector bench for des_decrypt_iter (R=1 main instance, R=2/4/16 side instances).
module tb_des_decrypt_iter;

    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] C1  = 64'h85E813540F0AB405;
    localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] C2  = 64'h8CA64DE9C1B123A7;
    localparam logic [63:0] K3  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P3  = 64'h8787878787878787;
    localparam logic [63:0] C4  = 64'h7359B2163E4EDC58;
    localparam logic [63:0] ALL1 = 64'hFFFFFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] dat_in, key_in, dat_out;

    logic        m_in_valid, m_out_ready;
    logic [63:0] m_dat, m_key;
    logic        rdy2, rdy4, rdy16, ov2, ov4, ov16;
    logic [63:0] do2, do4, do16;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    des_decrypt_iter #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dat_in(dat_in), .key_in(key_in), .out_valid(out_valid),
        .out_ready(out_ready), .dat_out(dat_out)
    );

    des_decrypt_iter #(.ROUNDS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(rdy2),
        .dat_in(m_dat), .key_in(m_key), .out_valid(ov2),
        .out_ready(m_out_ready), .dat_out(do2)
    );

    des_decrypt_iter #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(rdy4),
        .dat_in(m_dat), .key_in(m_key), .out_valid(ov4),
        .out_ready(m_out_ready), .dat_out(do4)
    );

    des_decrypt_iter #(.ROUNDS_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(rdy16),
        .dat_in(m_dat), .key_in(m_key), .out_valid(ov16),
        .out_ready(m_out_ready), .dat_out(do16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one block to the R=1 instance, scrambles inputs after acceptance,
    // and returns cycles from the accept edge to out_valid plus the result.
    task automatic send_wait(input logic [63:0] key, input logic [63:0] ct,
                             output int lat, output logic [63:0] pt);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        dat_in = ct;
        key_in = key;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        dat_in = ~ct;
        key_in = ~key;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        pt = dat_out;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // One block into the three side instances at once; out_ready held low
    // until all have finished so each result stays visible.
    task automatic run_multi(input logic [63:0] key, input logic [63:0] ct,
                             output int l2, output int l4, output int l16,
                             output logic [63:0] p2, output logic [63:0] p4,
                             output logic [63:0] p16);
        l2 = -1; l4 = -1; l16 = -1;
        p2 = '0; p4 = '0; p16 = '0;
        m_in_valid = 1'b1;
        m_dat = ct;
        m_key = key;
        tick();
        m_in_valid = 1'b0;
        m_dat = ~ct;
        m_key = ~key;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ov2 && l2 < 0)   begin l2 = k;  p2 = do2;   end
            if (ov4 && l4 < 0)   begin l4 = k;  p4 = do4;   end
            if (ov16 && l16 < 0) begin l16 = k; p16 = do16; end
        end
        m_out_ready = 1'b1;
        tick();
        m_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || dat_out !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b dat_out=%h required 0 0 0",
                     in_ready, out_valid, dat_out);
        end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0",
                     in_ready, out_valid);
        end
        // out_ready without out_valid must do nothing.
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dat_out !== 64'h0) begin
            tests_failed++;
            $display("FAIL idle_out_ready: in_ready=%b out_valid=%b dat_out=%h required 1 0 0",
                     in_ready, out_valid, dat_out);
        end
        $display("[TB] reset checks done");
    endtask

    task automatic test_vector1();
        int lat;
        logic [63:0] pt;
        send_wait(K1, C1, lat, pt);
        tests_run++;
        if (pt !== P1) begin
            tests_failed++;
            $display("FAIL v1_data: got %h required %h", pt, P1);
        end
        tests_run++;
        if (lat !== 16) begin
            tests_failed++;
            $display("FAIL v1_latency: got %0d required 16", lat);
        end
        handshake();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL v1_after_hs: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        $display("[TB] v1 key=%h ct=%h pt=%h lat=%0d", K1, C1, pt, lat);
    endtask

    task automatic test_more_vectors();
        logic [63:0] keys [4];
        logic [63:0] cts  [4];
        logic [63:0] pts  [4];
        int lat;
        logic [63:0] pt;
        keys = '{64'h0, 64'h0101010101010101, K3, ALL1};
        cts  = '{C2, C2, 64'h0, C4};
        pts  = '{64'h0, 64'h0, P3, ALL1};
        for (int i = 0; i < 4; i++) begin
            send_wait(keys[i], cts[i], lat, pt);
            tests_run++;
            if (pt !== pts[i] || lat !== 16) begin
                tests_failed++;
                $display("FAIL vec%0d: got %h lat %0d required %h lat 16", i, pt, lat, pts[i]);
            end
            handshake();
            $display("[TB] vec%0d key=%h ct=%h pt=%h lat=%0d", i, keys[i], cts[i], pt, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [63:0] pt;
        send_wait(K1, C1, lat, pt);
        in_valid = 1'b1;   // offered while busy: must be ignored
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dat_out !== P1) begin
                tests_failed++;
                $display("FAIL stall_%0d: out_valid=%b in_ready=%b dat_out=%h required 1 0 %h",
                         i, out_valid, in_ready, dat_out, P1);
            end
        end
        in_valid = 1'b0;
        handshake();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        $display("[TB] backpressure pt=%h", pt);
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [63:0] pt;
        in_valid = 1'b1;
        dat_in = C1;
        key_in = K1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || dat_out !== 64'h0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: out_valid=%b dat_out=%h in_ready=%b required 0 0 0",
                     out_valid, dat_out, in_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        send_wait(K1, C1, lat, pt);
        tests_run++;
        if (pt !== P1 || lat !== 16) begin
            tests_failed++;
            $display("FAIL post_reset_v1: got %h lat %0d required %h lat 16", pt, lat, P1);
        end
        handshake();
        $display("[TB] reset mid-round then pt=%h", pt);
    endtask

    task automatic test_back_to_back();
        int lat;
        in_valid = 1'b1;
        dat_in = C1;
        key_in = K1;
        tick();
        // Second block offered immediately; also a mid-round change of key_in.
        dat_in = C2;
        key_in = 64'h0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_busy_ready: in_ready=%b required 0 at cycle %0d", in_ready, lat);
            end
            tick();
            lat++;
        end
        tests_run++;
        if (dat_out !== P1 || lat !== 16) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h lat %0d required %h lat 16", dat_out, lat, P1);
        end
        $display("[TB] b2b first pt=%h lat=%0d", dat_out, lat);
        handshake();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_gap: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        tests_run++;
        if (dat_out !== 64'h0 || lat !== 16) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h lat %0d required 0 lat 16", dat_out, lat);
        end
        $display("[TB] b2b second pt=%h lat=%0d", dat_out, lat);
        handshake();
    endtask

    task automatic test_multi();
        int l2, l4, l16;
        logic [63:0] p2, p4, p16;
        logic [63:0] cts  [2];
        logic [63:0] keys [2];
        logic [63:0] pts  [2];
        cts  = '{C1, C2};
        keys = '{K1, 64'h0};
        pts  = '{P1, 64'h0};
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (rdy2 !== 1'b1 || rdy4 !== 1'b1 || rdy16 !== 1'b1) begin
                tests_failed++;
                $display("FAIL multi_ready_%0d: %b%b%b required 111", i, rdy2, rdy4, rdy16);
            end
            run_multi(keys[i], cts[i], l2, l4, l16, p2, p4, p16);
            tests_run++;
            if (p2 !== pts[i] || l2 !== 8) begin
                tests_failed++;
                $display("FAIL r2_vec%0d: got %h lat %0d required %h lat 8", i, p2, l2, pts[i]);
            end
            tests_run++;
            if (p4 !== pts[i] || l4 !== 4) begin
                tests_failed++;
                $display("FAIL r4_vec%0d: got %h lat %0d required %h lat 4", i, p4, l4, pts[i]);
            end
            tests_run++;
            if (p16 !== pts[i] || l16 !== 1) begin
                tests_failed++;
                $display("FAIL r16_vec%0d: got %h lat %0d required %h lat 1", i, p16, l16, pts[i]);
            end
            $display("[TB] multi vec%0d lat=%0d/%0d/%0d pt=%h/%h/%h", i, l2, l4, l16, p2, p4, p16);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dat_in = '0;
        key_in = '0;
        m_in_valid = 1'b0;
        m_out_ready = 1'b0;
        m_dat = '0;
        m_key = '0;
        test_reset();
        test_vector1();
        test_more_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_multi();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
